// File: rtl/div_sqrt_quotient_collector_if.sv
// Handshake/data bundle between the div/sqrt iteration cell, control FSM and quotient collector.
// Carries no logic; the master modport is the driver side (control + iteration cell),
// the slave modport is the collector itself.
interface div_sqrt_quotient_collector_if #(
  parameter int C_WIDTH = 54,
  parameter int C_CNT_W = 6
);
  logic               Start_SI;
  logic               Kill_SI;
  logic [C_CNT_W-1:0] Iter_num_DI;
  logic               Bit_valid_SI;
  logic               Carry_DI;
  logic               Rem_zero_SI;
  logic               Add_sub_SO;
  logic               Busy_SO;
  logic               Done_SO;
  logic [C_WIDTH-1:0] Quot_DO;
  logic               Sticky_SO;

  modport master (
    output Start_SI, Kill_SI, Iter_num_DI, Bit_valid_SI, Carry_DI, Rem_zero_SI,
    input  Add_sub_SO, Busy_SO, Done_SO, Quot_DO, Sticky_SO
  );

  modport slave (
    input  Start_SI, Kill_SI, Iter_num_DI, Bit_valid_SI, Carry_DI, Rem_zero_SI,
    output Add_sub_SO, Busy_SO, Done_SO, Quot_DO, Sticky_SO
  );
endinterface

// File: rtl/div_sqrt_quotient_collector.sv
// Purpose: shifts iteration-cell carry-outs into the quotient, derives sticky, steers add/sub.
// Latency: Done pulses one cycle after the N-th valid bit is sampled (N+1 cycles with no stalls).
// Backpressure: none; Bit_valid_SI low simply stalls collection, bits outside COLLECT are dropped.
module div_sqrt_quotient_collector #(
  parameter int C_WIDTH = 54,
  parameter int C_CNT_W = 6
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  div_sqrt_quotient_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [C_CNT_W-1:0] MAX_N = C_CNT_W'(C_WIDTH);

  state_e             state_q, state_d;
  logic [C_WIDTH-1:0] quot_q, quot_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [C_CNT_W-1:0] n_q, n_d;
  logic               add_sub_q, add_sub_d;
  logic               sticky_q, sticky_d;

  logic [C_CNT_W-1:0] n_sat;
  logic [C_CNT_W-1:0] cnt_inc;

  // Zero or oversize iteration counts mean "full width".
  always_comb begin
    n_sat = bus.Iter_num_DI;
    if ((bus.Iter_num_DI == '0) || (bus.Iter_num_DI > MAX_N)) begin
      n_sat = MAX_N;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and datapath: kill beats start, start beats an incoming bit.
  always_comb begin
    state_d   = state_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    add_sub_d = add_sub_q;
    sticky_d  = sticky_q;

    if (bus.Kill_SI) begin
      state_d   = IDLE;
      quot_d    = '0;
      cnt_d     = '0;
      add_sub_d = 1'b1;
      sticky_d  = 1'b0;
    end else if (bus.Start_SI) begin
      state_d   = COLLECT;
      quot_d    = '0;
      cnt_d     = '0;
      n_d       = n_sat;
      add_sub_d = 1'b1;
      sticky_d  = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (bus.Bit_valid_SI) begin
            quot_d    = {quot_q[C_WIDTH-2:0], bus.Carry_DI};
            cnt_d     = cnt_inc;
            add_sub_d = bus.Carry_DI;
            if (cnt_inc == n_q) begin
              // A negative remainder also reads as nonzero; rounding corrects it later.
              sticky_d = ~bus.Rem_zero_SI;
              state_d  = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      quot_q    <= '0;
      cnt_q     <= '0;
      n_q       <= MAX_N;
      add_sub_q <= 1'b1;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      add_sub_q <= add_sub_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bus.Quot_DO    = quot_q;
  assign bus.Sticky_SO  = sticky_q;
  assign bus.Add_sub_SO = add_sub_q;
  assign bus.Busy_SO    = (state_q == COLLECT);
  assign bus.Done_SO    = (state_q == DONE);

endmodule

// File: tb/tb_div_sqrt_quotient_collector.sv
// Directed bench for the div/sqrt quotient collector.
// Inputs change and outputs are sampled just after the falling edge.
// Expected values are hand-computed constants.
module tb_div_sqrt_quotient_collector;

  localparam int C_WIDTH = 54;
  localparam int C_CNT_W = 6;

  logic Clk_CI = 1'b0;
  logic Rst_RI = 1'b1;

  int checks = 0;
  int errors = 0;

  div_sqrt_quotient_collector_if #(.C_WIDTH(C_WIDTH), .C_CNT_W(C_CNT_W)) bus ();

  div_sqrt_quotient_collector #(.C_WIDTH(C_WIDTH), .C_CNT_W(C_CNT_W)) dut (
    .Clk_CI (Clk_CI),
    .Rst_RI (Rst_RI),
    .bus    (bus.slave)
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_CI);
    @(negedge Clk_CI);
  endtask

  task automatic drive(input logic st, input logic kl, input logic [C_CNT_W-1:0] n,
                       input logic vld, input logic cy, input logic rz);
    bus.Start_SI     = st;
    bus.Kill_SI      = kl;
    bus.Iter_num_DI  = n;
    bus.Bit_valid_SI = vld;
    bus.Carry_DI     = cy;
    bus.Rem_zero_SI  = rz;
  endtask

  initial begin
    int n_bits;
    int cyc;
    int early_done;
    drive(0, 0, '0, 0, 0, 0);

    // Reset state
    tick();
    chk("rst_busy",   64'(bus.Busy_SO),    64'd0);
    chk("rst_done",   64'(bus.Done_SO),    64'd0);
    chk("rst_quot",   64'(bus.Quot_DO),    64'd0);
    chk("rst_sticky", 64'(bus.Sticky_SO),  64'd0);
    chk("rst_addsub", 64'(bus.Add_sub_SO), 64'd1);
    Rst_RI = 1'b0;
    tick();

    // Basic collect: N=4, bits 1,0,1,1, remainder zero at end
    drive(1, 0, 6'd4, 0, 0, 0);
    tick();
    drive(0, 0, 6'd4, 1, 1, 0);
    chk("basic_busy0",   64'(bus.Busy_SO),    64'd1);
    chk("basic_addsub0", 64'(bus.Add_sub_SO), 64'd1);
    chk("basic_quot0",   64'(bus.Quot_DO),    64'd0);
    tick();
    chk("basic_addsub1", 64'(bus.Add_sub_SO), 64'd1);
    chk("basic_done1",   64'(bus.Done_SO),    64'd0);
    drive(0, 0, 6'd4, 1, 0, 0);
    tick();
    chk("basic_addsub2", 64'(bus.Add_sub_SO), 64'd0);
    drive(0, 0, 6'd4, 1, 1, 0);
    tick();
    chk("basic_addsub3", 64'(bus.Add_sub_SO), 64'd1);
    chk("basic_done3",   64'(bus.Done_SO),    64'd0);
    chk("basic_quot3",   64'(bus.Quot_DO),    64'h5);
    drive(0, 0, 6'd4, 1, 1, 1);
    tick();
    chk("basic_done",    64'(bus.Done_SO),    64'd1);
    chk("basic_busy",    64'(bus.Busy_SO),    64'd0);
    chk("basic_quot",    64'(bus.Quot_DO),    64'hB);
    chk("basic_sticky",  64'(bus.Sticky_SO),  64'd0);
    chk("basic_addsub4", 64'(bus.Add_sub_SO), 64'd1);
    drive(0, 0, 6'd4, 0, 0, 0);
    tick();
    chk("basic_done_pulse", 64'(bus.Done_SO), 64'd0);
    chk("basic_quot_hold",  64'(bus.Quot_DO), 64'hB);

    // Ignore idle bits: carry 0 would flip add/sub if taken
    drive(0, 0, 6'd4, 1, 0, 0);
    tick();
    tick();
    drive(0, 0, 6'd4, 0, 0, 0);
    chk("idle_quot",   64'(bus.Quot_DO),    64'hB);
    chk("idle_sticky", 64'(bus.Sticky_SO),  64'd0);
    chk("idle_addsub", 64'(bus.Add_sub_SO), 64'd1);
    chk("idle_busy",   64'(bus.Busy_SO),    64'd0);

    // Full width with stalls: N=0 saturates to 54, every third cycle stalls
    drive(1, 0, 6'd0, 0, 0, 0);
    tick();
    n_bits = 0;
    cyc = 0;
    early_done = 0;
    while (n_bits < C_WIDTH && cyc < 200) begin
      drive(0, 0, 6'd0, (cyc % 3) != 2, 1, 0);
      tick();
      if (bus.Bit_valid_SI) n_bits++;
      if (n_bits < C_WIDTH && bus.Done_SO) early_done++;
      cyc++;
    end
    drive(0, 0, 6'd0, 0, 0, 0);
    chk("full_bits",       64'(n_bits),        64'd54);
    chk("full_early_done", 64'(early_done),    64'd0);
    chk("full_done",       64'(bus.Done_SO),   64'd1);
    chk("full_quot",       64'(bus.Quot_DO),   64'h003F_FFFF_FFFF_FFFF);
    chk("full_sticky",     64'(bus.Sticky_SO), 64'd1);
    tick();
    chk("full_done_pulse", 64'(bus.Done_SO),   64'd0);

    // Kill after 3 bits of an N=8 operation, together with a valid bit
    drive(1, 0, 6'd8, 0, 0, 0);
    tick();
    drive(0, 0, 6'd8, 1, 1, 0);
    tick();
    drive(0, 0, 6'd8, 1, 0, 0);
    tick();
    drive(0, 0, 6'd8, 1, 1, 0);
    tick();
    chk("kill_pre_quot", 64'(bus.Quot_DO), 64'h5);
    drive(0, 1, 6'd8, 1, 1, 0);
    tick();
    drive(0, 0, 6'd8, 0, 0, 0);
    chk("kill_busy",   64'(bus.Busy_SO),    64'd0);
    chk("kill_done",   64'(bus.Done_SO),    64'd0);
    chk("kill_quot",   64'(bus.Quot_DO),    64'd0);
    chk("kill_sticky", 64'(bus.Sticky_SO),  64'd0);
    chk("kill_addsub", 64'(bus.Add_sub_SO), 64'd1);
    tick();
    chk("kill_no_done", 64'(bus.Done_SO), 64'd0);
    drive(1, 1, 6'd8, 0, 0, 0);
    tick();
    drive(0, 0, 6'd8, 0, 0, 0);
    chk("kill_start_busy", 64'(bus.Busy_SO), 64'd0);
    tick();
    chk("kill_start_busy2", 64'(bus.Busy_SO), 64'd0);

    // Restart mid-collect after 2 bits, then N=3 bits 1,1,0
    drive(1, 0, 6'd8, 0, 0, 0);
    tick();
    drive(0, 0, 6'd8, 1, 1, 0);
    tick();
    tick();
    chk("rs_pre_quot", 64'(bus.Quot_DO), 64'h3);
    drive(1, 0, 6'd3, 1, 1, 0);
    tick();
    chk("rs_quot0",   64'(bus.Quot_DO),    64'd0);
    chk("rs_busy0",   64'(bus.Busy_SO),    64'd1);
    chk("rs_addsub0", 64'(bus.Add_sub_SO), 64'd1);
    drive(0, 0, 6'd3, 1, 1, 0);
    tick();
    tick();
    chk("rs_done_mid", 64'(bus.Done_SO), 64'd0);
    drive(0, 0, 6'd3, 1, 0, 0);
    tick();
    chk("rs_done",   64'(bus.Done_SO),   64'd1);
    chk("rs_quot",   64'(bus.Quot_DO),   64'h6);
    chk("rs_sticky", 64'(bus.Sticky_SO), 64'd1);
    // Back-to-back start in the DONE cycle, N=2 bits 0,1
    drive(1, 0, 6'd2, 0, 0, 0);
    tick();
    chk("b2b_busy", 64'(bus.Busy_SO), 64'd1);
    chk("b2b_done", 64'(bus.Done_SO), 64'd0);
    chk("b2b_quot", 64'(bus.Quot_DO), 64'd0);
    drive(0, 0, 6'd2, 1, 0, 0);
    tick();
    drive(0, 0, 6'd2, 1, 1, 1);
    tick();
    drive(0, 0, 6'd2, 0, 0, 0);
    chk("b2b_done2",  64'(bus.Done_SO),   64'd1);
    chk("b2b_quot2",  64'(bus.Quot_DO),   64'h1);
    chk("b2b_sticky", 64'(bus.Sticky_SO), 64'd0);
    tick();

    // Asynchronous reset mid-collect
    drive(1, 0, 6'd5, 0, 0, 0);
    tick();
    drive(0, 0, 6'd5, 1, 1, 0);
    tick();
    drive(0, 0, 6'd5, 1, 0, 0);
    tick();
    drive(0, 0, 6'd5, 0, 0, 0);
    chk("ar_pre_quot",   64'(bus.Quot_DO),    64'h2);
    chk("ar_pre_addsub", 64'(bus.Add_sub_SO), 64'd0);
    @(posedge Clk_CI);
    #2;
    Rst_RI = 1'b1;
    #1;
    chk("ar_busy",   64'(bus.Busy_SO),    64'd0);
    chk("ar_done",   64'(bus.Done_SO),    64'd0);
    chk("ar_quot",   64'(bus.Quot_DO),    64'd0);
    chk("ar_sticky", 64'(bus.Sticky_SO),  64'd0);
    chk("ar_addsub", 64'(bus.Add_sub_SO), 64'd1);
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    tick();
    chk("ar_no_done", 64'(bus.Done_SO), 64'd0);
    chk("ar_idle",    64'(bus.Busy_SO), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
